// File: rtl/act_ser_pkg.sv
// Shared types and helpers for the activation-vector serializer.
// Optional argmax tracking is enabled with the ACT_SER_ARGMAX_EN macro.
package act_ser_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // Width of a counter addressing n items; never collapses to zero bits.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/act_ser_argmax.sv
// Running signed maximum over the beats of one vector; lowest channel wins ties.
// Built into act_vec_serializer only when ACT_SER_ARGMAX_EN is defined.
module act_ser_argmax
   import act_ser_pkg::*;
#(
   parameter int NBITS = 16,
   parameter int LANES = 1,
   parameter int IDXW  = 8,
   parameter int AIW   = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   hs_i,
   input  logic                   first_i,
   input  logic                   last_i,
   input  logic [IDXW-1:0]        beat_idx_i,
   input  logic [NBITS*LANES-1:0] beat_data_i,
   output logic [AIW-1:0]         argmax_idx_o,
   output logic                   argmax_valid_o
);

   localparam int LW = cnt_w(LANES);

   logic signed [NBITS-1:0] beat_max;
   logic [LW-1:0]           beat_lane;
   logic [AIW-1:0]          beat_cidx;
   logic signed [NBITS-1:0] run_max_q, cand_max;
   logic [AIW-1:0]          run_idx_q, cand_idx;
   logic                    take;
   logic [AIW-1:0]          argmax_idx_q;
   logic                    argmax_valid_q;

   // Strict '>' across lanes keeps the lowest lane on ties.
   always_comb begin
      beat_max  = signed'(beat_data_i[NBITS-1:0]);
      beat_lane = '0;
      for (int l = 1; l < LANES; l++) begin
         if (signed'(beat_data_i[l*NBITS +: NBITS]) > beat_max) begin
            beat_max  = signed'(beat_data_i[l*NBITS +: NBITS]);
            beat_lane = LW'(l);
         end
      end
      beat_cidx = AIW'(int'(beat_idx_i) * LANES + int'(beat_lane));
      take      = first_i || (beat_max > run_max_q);
      cand_max  = take ? beat_max  : run_max_q;
      cand_idx  = take ? beat_cidx : run_idx_q;
   end

   // Running max needs no reset: beat 0 of every vector reloads it.
   always_ff @(posedge clk) begin
      if (hs_i) begin
         run_max_q <= cand_max;
         run_idx_q <= cand_idx;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         argmax_idx_q   <= '0;
         argmax_valid_q <= 1'b0;
      end else begin
         argmax_valid_q <= hs_i && last_i;
         if (hs_i && last_i) argmax_idx_q <= cand_idx;
      end
   end

   assign argmax_idx_o   = argmax_idx_q;
   assign argmax_valid_o = argmax_valid_q;

endmodule

// File: rtl/act_vec_serializer.sv
// Captures pooled activation vectors and streams them LANES channels per beat.
// Define ACT_SER_ARGMAX_EN to build the per-vector argmax tracker.
module act_vec_serializer
   import act_ser_pkg::*;
#(
   parameter int NBITS  = 16,
   parameter int NFMAPS = 256,
   parameter int LANES  = 1
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      valid,
   input  logic [NBITS*NFMAPS-1:0]   input_act,
   input  logic                      clr_ovf,
   output logic [NBITS*LANES-1:0]    out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_last,
   output logic                      busy,
   output logic                      overflow,
   output logic [cnt_w(NFMAPS)-1:0]  argmax_idx,
   output logic                      argmax_valid
);

   localparam int NBEATS = NFMAPS / LANES;
   localparam int IDXW   = cnt_w(NBEATS);
   localparam int VW     = NBITS * NFMAPS;
   localparam int BW     = NBITS * LANES;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBEATS - 1);

   if (NFMAPS % LANES != 0) begin : g_lanes_chk
      $error("NFMAPS must be a multiple of LANES");
   end

   state_e          state_q, state_d;
   logic [VW-1:0]   active_q, active_d;
   logic [VW-1:0]   pend_q, pend_d;
   logic            pend_full_q, pend_full_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            ovf_q, ovf_d;
   logic            hs, last_beat, last_hs, drop;

   assign hs        = out_valid && out_ready;
   assign last_beat = (idx_q == LAST_IDX);
   assign last_hs   = hs && last_beat;

   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      idx_d       = idx_q;
      drop        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (valid) begin
               active_d = input_act;
               idx_d    = '0;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (last_hs) begin
               idx_d = '0;
               // A vector arriving with the last beat refills whichever slot frees up.
               if (pend_full_q) begin
                  active_d = pend_q;
                  if (valid) pend_d = input_act;
                  else       pend_full_d = 1'b0;
               end else if (valid) begin
                  active_d = input_act;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (hs) idx_d = idx_q + 1'b1;
               if (valid) begin
                  if (pend_full_q) begin
                     drop = 1'b1;
                  end else begin
                     pend_d      = input_act;
                     pend_full_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         pend_full_q <= 1'b0;
         idx_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_full_q <= pend_full_d;
         idx_q       <= idx_d;
         ovf_q       <= ovf_d;
      end
   end

   // Vector storage carries no reset; out_data is gated while nothing is sent.
   always_ff @(posedge clk) begin
      active_q <= active_d;
      pend_q   <= pend_d;
   end

   assign out_valid = (state_q == SEND);
   assign out_last  = out_valid && last_beat;
   assign busy      = out_valid || pend_full_q;
   assign overflow  = ovf_q;
   assign out_data  = out_valid ? active_q[idx_q*BW +: BW] : '0;

`ifdef ACT_SER_ARGMAX_EN
   act_ser_argmax #(
      .NBITS (NBITS),
      .LANES (LANES),
      .IDXW  (IDXW),
      .AIW   (cnt_w(NFMAPS))
   ) u_argmax (
      .clk            (clk),
      .rstn           (rstn),
      .hs_i           (hs),
      .first_i        (idx_q == '0),
      .last_i         (last_beat),
      .beat_idx_i     (idx_q),
      .beat_data_i    (out_data),
      .argmax_idx_o   (argmax_idx),
      .argmax_valid_o (argmax_valid)
   );
`else
   assign argmax_idx   = '0;
   assign argmax_valid = 1'b0;
`endif

endmodule

// File: doc/act_vec_serializer.md
# act_vec_serializer

Output stage placed directly after the final average-pool stage of the MobileNet pipeline. It captures each wide pooled activation vector, NFMAPS channels of NBITS each, on a single-cycle `valid` pulse. It then streams the vector out LANES channels per beat over a valid/ready interface. It buffers one pending vector and flags overflow, because the upstream pipeline cannot be stalled.

## Interface
Parameters:
- NBITS, 16, bits per channel; two's complement.
- NFMAPS, 256, channels per vector.
- LANES, 1, channels per output beat. NFMAPS % LANES == 0 is required; elaboration fails otherwise.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- valid  in  1  single-cycle pulse; `input_act` is valid in this cycle.
- input_act  in  NBITS*NFMAPS  vector; channel c occupies bits [c*NBITS +: NBITS].
- clr_ovf  in  1  synchronous clear of `overflow`.
- out_data  out  NBITS*LANES  current beat; lane l carries channel idx*LANES+l.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts the beat.
- out_last  out  1  final beat of the vector.
- busy  out  1  active or pending vector held.
- overflow  out  1  sticky; a vector was dropped.
- argmax_idx  out  $clog2(NFMAPS)  index of the largest channel in the last completed vector.
- argmax_valid  out  1  one-cycle pulse when `argmax_idx` updates.

## Operation
- Storage: ACTIVE register holding the vector being sent, beat counter `idx` (0..NFMAPS/LANES-1), PENDING register, and `pend_full` flag.
- FSM states:
  - IDLE: on `valid`, load ACTIVE, idx=0, go to SEND.
  - SEND: on handshake (`out_valid && out_ready`), idx++.
  - On the handshake of the last beat: if `pend_full`, move PENDING to ACTIVE, idx=0, stay in SEND. Else if `valid` in the same cycle, load `input_act` into ACTIVE and stay in SEND. Else go to IDLE.
- `valid` while in SEND: if not `pend_full`, capture into PENDING.
- `valid` while `pend_full` and not a last-beat handshake: drop the vector, set `overflow`.
- Simultaneous `valid`, last-beat handshake and `pend_full`: PENDING moves to ACTIVE and the new vector goes to PENDING. Nothing is dropped.
- `overflow` stays set until `clr_ovf` or reset. If `clr_ovf` and a drop occur in the same cycle, `overflow` stays 1.
- `out_data` = ACTIVE slice at `idx`. It is held stable while `out_valid && !out_ready`. `out_valid` never drops without a handshake.
- `out_last` = `out_valid && idx == NFMAPS/LANES-1`.
- `busy` = (state == SEND) || `pend_full`.

## Timing
- Reset values: out_valid=0, out_last=0, busy=0, overflow=0, argmax_idx=0, argmax_valid=0, out_data=0, state IDLE, pend_full=0.
- Latency: `valid` sampled at edge t means `out_valid`=1 with beat 0 after edge t.
- Throughput: one beat per cycle while `out_ready`=1. Zero-bubble transition between a last beat and the next vector's beat 0.
- Reset asserted mid-vector: all state clears immediately; the partial vector and PENDING are discarded. No beats are emitted after release until a new `valid`.

## Configuration
- Macro ACT_SER_ARGMAX_EN.
- Defined: a running signed maximum over beats, updated on each handshake, with strict `>` comparison so ties resolve to the lowest index. On the cycle after the last-beat handshake, `argmax_idx` is updated and `argmax_valid` pulses for 1 cycle.
- Undefined: the comparator logic is not built; `argmax_idx`=0 and `argmax_valid`=0 constantly. The ports are always present.

## Structure
- Package `act_ser_pkg`: FSM state enum (IDLE, SEND) and helper function for beat-count width.
- Sub-module `act_ser_argmax`: LANES-wide signed compare tree plus running max/index registers. Instantiated only under ACT_SER_ARGMAX_EN.

## Test plan
All scenarios use NFMAPS=256, LANES=1, NBITS=16.
- Single vector with channel c = 3*c, out_ready=1:
  - 256 beats with data 0,3,…,765; out_valid asserted the cycle after valid.
  - out_last only on data 765; busy drops after the last beat.
- Backpressure with out_ready pattern 1,0,1,0…: out_data and out_valid are held during stalls, exactly 256 accepts in order, no duplicates.
- Second valid at beat 10 of vector A (B: c = c+1000): B follows A's beat 255 with no idle cycle; B beat 0 = 1000.
- Overflow: vectors A, B and C with C arriving while A is sending and B is pending:
  - overflow=1; A and B are delivered intact and C never appears.
  - clr_ovf returns overflow to 0.
  - Variant: C arrives in the same cycle as A's last handshake → no overflow, and A, B, C are all delivered.
- Reset asserted at beat 100:
  - out_valid=0 and busy=0 immediately.
  - No beats after release; a fresh vector then restarts at beat 0.
- ACT_SER_ARGMAX_EN defined, all channels = 0x8000 except ch 77 = 0x7FFF and ch 200 = 0x7FFF: argmax_valid pulses once with argmax_idx = 77.
